// File: rtl/blastit_cmd_parser_pkg.sv
// Shared definitions for the blastit command parser: command codes,
// response codes, FSM state encodings and small decode helpers.
package blastit_cmd_parser_pkg;

    // Command codes carried in the CMD byte of a frame
    localparam logic [7:0] CMD_SET_VALUE = 8'h01;
    localparam logic [7:0] CMD_SET_BAR   = 8'h02;
    localparam logic [7:0] CMD_SET_WARN  = 8'h03;
    localparam logic [7:0] CMD_PING      = 8'h04;

    // Response bytes: ACK echoes the command with the top bit set
    localparam logic [7:0] RSP_ACK_MASK  = 8'h80;
    localparam logic [7:0] RSP_NAK       = 8'h15;

    // FSM state encodings
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_LO   = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
    localparam logic [2:0] S_EXEC = 3'd5;
    localparam logic [2:0] S_RESP = 3'd6;

    // A frame is intact when the check byte is the XOR of the payload bytes
    function automatic logic frame_ok(input logic [7:0] cmd,
                                      input logic [7:0] hi,
                                      input logic [7:0] lo,
                                      input logic [7:0] chk);
        return chk == (cmd ^ hi ^ lo);
    endfunction

    // States in which the parser is between bytes of an open frame
    function automatic logic in_frame_state(input logic [2:0] s);
        return (s == S_CMD) || (s == S_HI) || (s == S_LO) || (s == S_CHK);
    endfunction

endpackage

// File: rtl/blastit_timeout.sv
// Inter-byte timeout counter: loadable up-counter with synchronous clear,
// count enable and a terminal-count flag at TIMEOUT_CYCLES-1. The counter
// parks on the terminal value rather than wrapping.
module blastit_timeout #(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int CNT_W          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = (cnt == TC_VAL);

    // Clear has priority over load; counting stops once terminal count is hit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && !tc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/blastit_cmd_parser.sv
// Command parser between the UART FIFOs and the board display registers.
// Decodes 5-byte frames SYNC, CMD, HI, LO, CHK and replies with one
// ACK/NAK byte per complete frame.
//
// Handshake: rd_uart is a one-cycle pop, raised combinationally only while
// rx_empty=0 and the byte on r_data is latched in that same cycle; after
// every pop there is one cycle with rd_uart low. wr_uart is a registered
// one-cycle push, only raised when tx_full was 0 the cycle before, with
// w_data valid in the same cycle.
module blastit_cmd_parser
    import blastit_cmd_parser_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 2_500_000,
    parameter int         BAR_MAX        = 10,
    parameter int         ERR_W          = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx_empty,
    input  logic [7:0]       r_data,
    output logic             rd_uart,
    input  logic             tx_full,
    output logic [7:0]       w_data,
    output logic             wr_uart,
    output logic [15:0]      disp_value,
    output logic [3:0]       bar_level,
    output logic             warn,
    output logic             upd_stb,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       dbg_state
);

    localparam int         TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0] BAR_MAX_B = 8'(BAR_MAX);

    logic [2:0]       state;
    logic [7:0]       cmd_q;
    logic [7:0]       hi_q;
    logic [7:0]       lo_q;
    logic [7:0]       chk_q;
    logic             nak_q;
    logic             pop_gap;
    logic             to_tc;
    logic             in_frame;
    logic             in_wait;
    logic             timed_out;
    logic             exec_nak;
    logic             exec_wr_value;
    logic             exec_wr_bar;
    logic             exec_wr_warn;
    logic [ERR_W-1:0] err_sat_inc;

    assign dbg_state = state;
    assign in_frame  = in_frame_state(state);
    assign in_wait   = in_frame || (state == S_IDLE);
    assign timed_out = in_frame && to_tc;

    // pop_gap resets high so nothing is popped while reset is held
    assign rd_uart = in_wait && !rx_empty && !pop_gap && !timed_out;

    assign err_sat_inc = (&err_cnt) ? err_cnt : err_cnt + ERR_W'(1);

    // Inter-byte timer: restarts on every pop and outside an open frame
    blastit_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (TO_W)
    ) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (rd_uart || !in_frame),
        .load     (1'b0),
        .load_val ('0),
        .en       (in_frame && rx_empty),
        .tc       (to_tc)
    );

    // Decode the captured frame into register writes or a NAK
    always_comb begin
        exec_nak      = 1'b0;
        exec_wr_value = 1'b0;
        exec_wr_bar   = 1'b0;
        exec_wr_warn  = 1'b0;
        if (!frame_ok(cmd_q, hi_q, lo_q, chk_q)) begin
            exec_nak = 1'b1;
        end else begin
            case (cmd_q)
                CMD_SET_VALUE: exec_wr_value = 1'b1;
                CMD_SET_BAR: begin
                    if (lo_q <= BAR_MAX_B) exec_wr_bar = 1'b1;
                    else                   exec_nak    = 1'b1;
                end
                CMD_SET_WARN:  exec_wr_warn = 1'b1;
                CMD_PING:      ;
                default:       exec_nak = 1'b1;
            endcase
        end
    end

    // Frame FSM, byte capture, display registers and response output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cmd_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            chk_q      <= '0;
            nak_q      <= 1'b0;
            pop_gap    <= 1'b1;
            w_data     <= '0;
            wr_uart    <= 1'b0;
            disp_value <= '0;
            bar_level  <= '0;
            warn       <= 1'b0;
            upd_stb    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            wr_uart <= 1'b0;
            upd_stb <= 1'b0;
            pop_gap <= rd_uart;
            case (state)
                S_IDLE: begin
                    // Anything other than the sync byte is dropped silently
                    if (rd_uart && (r_data == SYNC_BYTE)) state <= S_CMD;
                end
                S_CMD: begin
                    if (timed_out) begin
                        state   <= S_IDLE;
                        err_cnt <= err_sat_inc;
                    end else if (rd_uart) begin
                        cmd_q <= r_data;
                        state <= S_HI;
                    end
                end
                S_HI: begin
                    if (timed_out) begin
                        state   <= S_IDLE;
                        err_cnt <= err_sat_inc;
                    end else if (rd_uart) begin
                        hi_q  <= r_data;
                        state <= S_LO;
                    end
                end
                S_LO: begin
                    if (timed_out) begin
                        state   <= S_IDLE;
                        err_cnt <= err_sat_inc;
                    end else if (rd_uart) begin
                        lo_q  <= r_data;
                        state <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (timed_out) begin
                        state   <= S_IDLE;
                        err_cnt <= err_sat_inc;
                    end else if (rd_uart) begin
                        chk_q <= r_data;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_wr_value) disp_value <= {hi_q, lo_q};
                    if (exec_wr_bar)   bar_level  <= lo_q[3:0];
                    if (exec_wr_warn)  warn       <= lo_q[0];
                    upd_stb <= exec_wr_value || exec_wr_bar || exec_wr_warn;
                    nak_q   <= exec_nak;
                    if (exec_nak) err_cnt <= err_sat_inc;
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (!tx_full) begin
                        wr_uart <= 1'b1;
                        w_data  <= nak_q ? RSP_NAK : (RSP_ACK_MASK | cmd_q);
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blastit_cmd_parser.sv
// Directed bench for blastit_cmd_parser: an RX FIFO model feeding frames,
// a TX log checked against an expected-byte queue, and register checks.
module tb_blastit_cmd_parser;

    localparam int TO_CYC = 1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_empty = 1'b1;
    logic [7:0]  r_data = 8'h00;
    logic        rd_uart;
    logic        tx_full = 1'b0;
    logic [7:0]  w_data;
    logic        wr_uart;
    logic [15:0] disp_value;
    logic [3:0]  bar_level;
    logic        warn;
    logic        upd_stb;
    logic [7:0]  err_cnt;
    logic [2:0]  dbg_state;

    blastit_cmd_parser #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO_CYC),
        .BAR_MAX        (10),
        .ERR_W          (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_empty   (rx_empty),
        .r_data     (r_data),
        .rd_uart    (rd_uart),
        .tx_full    (tx_full),
        .w_data     (w_data),
        .wr_uart    (wr_uart),
        .disp_value (disp_value),
        .bar_level  (bar_level),
        .warn       (warn),
        .upd_stb    (upd_stb),
        .err_cnt    (err_cnt),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] stage_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    logic [7:0] exp_q[$];

    bit do_pop = 0;
    bit prev_rd = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    int wr_lat = 0;
    int upd_cnt = 0;
    int viol_empty = 0;
    int viol_gap = 0;
    int viol_full = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // RX FIFO model: applies pops and new bytes just after each rising edge
    always @(posedge clk) begin
        cyc++;
        #1;
        if (do_pop) begin
            if (rx_q.size() > 0) void'(rx_q.pop_front());
            do_pop = 0;
        end
        while (stage_q.size() > 0) rx_q.push_back(stage_q.pop_front());
        rx_empty = (rx_q.size() == 0);
        r_data   = rx_empty ? 8'h00 : rx_q[0];
    end

    // Output monitor on the falling edge
    always @(negedge clk) begin
        if (rd_uart && rx_empty) viol_empty++;
        if (rd_uart && prev_rd)  viol_gap++;
        prev_rd = rd_uart;
        do_pop  = rd_uart;
        if (rd_uart) last_pop_cyc = cyc;
        if (wr_uart) begin
            if (tx_full) viol_full++;
            tx_log.push_back(w_data);
            wr_lat = cyc - last_pop_cyc;
        end
        if (upd_stb) upd_cnt++;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic push_bytes5(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input logic [7:0] b4);
        stage_q.push_back(b0);
        stage_q.push_back(b1);
        stage_q.push_back(b2);
        stage_q.push_back(b3);
        stage_q.push_back(b4);
    endtask

    // scoreboard: wait for the next TX byte and compare with the expectation
    task automatic expect_tx(input logic [7:0] b, input int budget);
        int n;
        n = 0;
        exp_q.push_back(b);
        while (tx_log.size() < exp_q.size() && n < budget) begin
            tick();
            n++;
        end
        check_eq("tx_arrived", 32'(tx_log.size() >= exp_q.size()), 32'd1);
        if (tx_log.size() >= exp_q.size())
            check_eq("tx_byte", 32'(tx_log[exp_q.size()-1]), 32'(b));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_disp"},  32'(disp_value), 32'h0);
        check_eq({tag, "_bar"},   32'(bar_level),  32'h0);
        check_eq({tag, "_warn"},  32'(warn),       32'h0);
        check_eq({tag, "_err"},   32'(err_cnt),    32'h0);
        check_eq({tag, "_wr"},    32'(wr_uart),    32'h0);
        check_eq({tag, "_rd"},    32'(rd_uart),    32'h0);
        check_eq({tag, "_upd"},   32'(upd_stb),    32'h0);
        check_eq({tag, "_wdata"}, 32'(w_data),     32'h0);
        check_eq({tag, "_state"}, 32'(dbg_state),  32'h0);
    endtask

    int upd_base;
    int tx_base;

    initial begin
        // reset, with a byte already waiting so a pop during reset would show
        reset_n = 1'b0;
        stage_q.push_back(8'h00);
        wait_cycles(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        wait_cycles(4);

        // 1: SET_VALUE 0x1234 (checksum 01^12^34 = 27)
        upd_base = upd_cnt;
        push_bytes5(8'hA5, 8'h01, 8'h12, 8'h34, 8'h27);
        expect_tx(8'h81, 200);
        check_eq("t1_latency", 32'(wr_lat), 32'd3);
        check_eq("t1_disp", 32'(disp_value), 32'h1234);
        check_eq("t1_upd", 32'(upd_cnt - upd_base), 32'd1);
        check_eq("t1_err", 32'(err_cnt), 32'd0);

        // 2: SET_BAR 7, then illegal 11, then the BAR_MAX boundary 10
        push_bytes5(8'hA5, 8'h02, 8'h00, 8'h07, 8'h05);
        expect_tx(8'h82, 200);
        check_eq("t2_bar7", 32'(bar_level), 32'd7);
        upd_base = upd_cnt;
        push_bytes5(8'hA5, 8'h02, 8'h00, 8'h0B, 8'h09);
        expect_tx(8'h15, 200);
        check_eq("t2_bar_hold", 32'(bar_level), 32'd7);
        check_eq("t2_err", 32'(err_cnt), 32'd1);
        check_eq("t2_no_upd", 32'(upd_cnt - upd_base), 32'd0);
        push_bytes5(8'hA5, 8'h02, 8'h00, 8'h0A, 8'h08);
        expect_tx(8'h82, 200);
        check_eq("t2_bar_max", 32'(bar_level), 32'd10);

        // 3: SET_WARN with the TX FIFO full for 100 cycles
        tx_full = 1'b1;
        tx_base = tx_log.size();
        push_bytes5(8'hA5, 8'h03, 8'h00, 8'h01, 8'h02);
        wait_cycles(100);
        check_eq("t3_held", 32'(tx_log.size() - tx_base), 32'd0);
        check_eq("t3_warn", 32'(warn), 32'd1);
        check_eq("t3_state", 32'(dbg_state), 32'd6);
        tx_full = 1'b0;
        expect_tx(8'h83, 50);
        wait_cycles(10);
        check_eq("t3_single", 32'(tx_log.size() - tx_base), 32'd1);

        // 4: junk before sync, then PING; then bad checksums and unknown command
        upd_base = upd_cnt;
        stage_q.push_back(8'h00);
        stage_q.push_back(8'hFF);
        push_bytes5(8'hA5, 8'h04, 8'h00, 8'h00, 8'h04);
        expect_tx(8'h84, 200);
        check_eq("t4_err_ping", 32'(err_cnt), 32'd1);
        check_eq("t4_ping_no_upd", 32'(upd_cnt - upd_base), 32'd0);
        push_bytes5(8'hA5, 8'h01, 8'h12, 8'h34, 8'h00);
        expect_tx(8'h15, 200);
        check_eq("t4_disp_hold", 32'(disp_value), 32'h1234);
        check_eq("t4_err_chk", 32'(err_cnt), 32'd2);
        push_bytes5(8'hA5, 8'h01, 8'h12, 8'h34, 8'h26);
        expect_tx(8'h15, 200);
        check_eq("t4_err_chk2", 32'(err_cnt), 32'd3);
        push_bytes5(8'hA5, 8'h07, 8'h00, 8'h00, 8'h07);
        expect_tx(8'h15, 200);
        check_eq("t4_err_cmd", 32'(err_cnt), 32'd4);

        // 5: stall mid-frame past the timeout, then a valid frame
        tx_base = tx_log.size();
        stage_q.push_back(8'hA5);
        stage_q.push_back(8'h01);
        wait_cycles(TO_CYC + 100);
        check_eq("t5_idle", 32'(dbg_state), 32'd0);
        check_eq("t5_err", 32'(err_cnt), 32'd5);
        check_eq("t5_no_tx", 32'(tx_log.size() - tx_base), 32'd0);
        push_bytes5(8'hA5, 8'h01, 8'h55, 8'h66, 8'h32);
        expect_tx(8'h81, 200);
        check_eq("t5_disp", 32'(disp_value), 32'h5566);

        // 6: reset in the middle of a frame, then a fresh frame
        stage_q.push_back(8'hA5);
        stage_q.push_back(8'h01);
        stage_q.push_back(8'h12);
        wait_cycles(12);
        check_eq("t6_mid_frame", 32'(dbg_state), 32'd3);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(2);
        push_bytes5(8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h67);
        expect_tx(8'h81, 200);
        check_eq("t6_disp", 32'(disp_value), 32'hABCD);
        check_eq("t6_err", 32'(err_cnt), 32'd0);

        // error counter saturation over 300 NAK frames
        for (int i = 0; i < 300; i++) push_bytes5(8'hA5, 8'h01, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 300; i++) expect_tx(8'h15, 100);
        check_eq("sat_err", 32'(err_cnt), 32'hFF);
        check_eq("sat_disp", 32'(disp_value), 32'hABCD);

        // protocol checks over the whole run
        wait_cycles(5);
        check_eq("tx_count", 32'(tx_log.size()), 32'(exp_q.size()));
        check_eq("pop_while_empty", 32'(viol_empty), 32'd0);
        check_eq("pop_back_to_back", 32'(viol_gap), 32'd0);
        check_eq("push_while_full", 32'(viol_full), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // overall time limit
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
